// File: rtl/dmem_latency_responder.sv
// Data-memory responder with configurable latency, big-endian byte lanes and a high-water address register.
// Define DMEM_MMIO_EN to decode the stdout character sink and the exit trigger.
module dmem_latency_responder #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0800_0000,
  parameter int unsigned       LATENCY     = 1,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'hf000_0000,
  parameter logic [ADDR_W-1:0] EXIT_ADDR   = 32'hff00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MREQ,
  input  logic              WRITE,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] DAD,
  input  logic [DATA_W-1:0] DDT_I,
  output logic [DATA_W-1:0] DDT_O,
  output logic              ACKD_n,
  output logic [ADDR_W-1:0] MAX_DAD,
  output logic              STDOUT_VLD,
  output logic [7:0]        STDOUT_CHR,
  output logic              EXIT_REQ
);

  localparam int unsigned     IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned     CNT_W = $clog2(LATENCY + 1);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  if (LATENCY < 1 || DATA_W != 32 || DEPTH_WORDS < 2 || STDOUT_ADDR == EXIT_ADDR) begin : g_bad_params
    $error("dmem_latency_responder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  ddt_o_q, ddt_o_d;
  logic [ADDR_W-1:0]  max_dad_q, max_dad_d;
  logic               stdout_vld_q, stdout_vld_d;
  logic [7:0]         stdout_chr_q, stdout_chr_d;
  logic               exit_req_q, exit_req_d;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  logic               commit;
  logic [ADDR_W-1:0]  req_addr;
  logic               req_write;
  logic [1:0]         req_size;
  logic [DATA_W-1:0]  req_wdata;
  logic [ADDR_W-1:0]  off;
  logic               in_range;
  logic [IDX_W-1:0]   word_idx;
  logic [1:0]         lane;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  wr_word;
  logic [3:0]         be;
  logic               is_stdout;
  logic               is_exit;
  logic               ram_ok;
  logic               ram_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MREQ) begin
          addr_d  = DAD;
          write_d = WRITE;
          size_d  = SIZE;
          wdata_d = DDT_I;
          if (LATENCY == 1) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
          commit  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the commit happens on the accept edge, so the live inputs are the request.
  always_comb begin
    if (state_q == IDLE) begin
      req_addr  = DAD;
      req_write = WRITE;
      req_size  = SIZE;
      req_wdata = DDT_I;
    end else begin
      req_addr  = addr_q;
      req_write = write_q;
      req_size  = size_q;
      req_wdata = wdata_q;
    end
  end

  always_comb begin
    off      = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    word_idx = off[IDX_W+1:2];
    lane     = off[1:0];
    rd_word  = mem[word_idx];
    case (req_size)
      2'b00: begin
        load_data = rd_word;
        wr_word   = req_wdata;
        be        = 4'b1111;
      end
      2'b01: begin
        load_data = {16'h0000, (lane[1] ? rd_word[15:0] : rd_word[31:16])};
        wr_word   = {2{req_wdata[15:0]}};
        be        = lane[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        case (lane)
          2'd0:    load_data = {24'h000000, rd_word[31:24]};
          2'd1:    load_data = {24'h000000, rd_word[23:16]};
          2'd2:    load_data = {24'h000000, rd_word[15:8]};
          default: load_data = {24'h000000, rd_word[7:0]};
        endcase
        wr_word = {4{req_wdata[7:0]}};
        be      = 4'b1000 >> lane;
      end
    endcase
  end

`ifdef DMEM_MMIO_EN
  assign is_stdout = req_write && req_size[1] && (req_addr == STDOUT_ADDR);
  assign is_exit   = req_write && (req_addr == EXIT_ADDR);
`else
  assign is_stdout = 1'b0;
  assign is_exit   = 1'b0;
`endif

  assign ram_ok = in_range && !is_stdout && !is_exit;
  assign ram_we = commit && req_write && ram_ok && !rst;

  always_comb begin
    ddt_o_d      = ddt_o_q;
    max_dad_d    = max_dad_q;
    stdout_vld_d = 1'b0;
    stdout_chr_d = stdout_chr_q;
    exit_req_d   = 1'b0;
    if (commit) begin
      if (!req_write) begin
        ddt_o_d = ram_ok ? load_data : '0;
      end
      if (ram_ok && (req_addr > max_dad_q)) begin
        max_dad_d = req_addr;
      end
      stdout_vld_d = is_stdout;
      exit_req_d   = is_exit;
      if (is_stdout) begin
        stdout_chr_d = req_wdata[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      wdata_q      <= '0;
      ddt_o_q      <= '0;
      max_dad_q    <= '0;
      stdout_vld_q <= 1'b0;
      stdout_chr_q <= '0;
      exit_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      ddt_o_q      <= ddt_o_d;
      max_dad_q    <= max_dad_d;
      stdout_vld_q <= stdout_vld_d;
      stdout_chr_q <= stdout_chr_d;
      exit_req_q   <= exit_req_d;
    end
  end

  // Storage is deliberately not reset so program images survive a core reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  assign ACKD_n     = (state_q != ACK);
  assign DDT_O      = ddt_o_q;
  assign MAX_DAD    = max_dad_q;
  assign STDOUT_VLD = stdout_vld_q;
  assign STDOUT_CHR = stdout_chr_q;
  assign EXIT_REQ   = exit_req_q;

endmodule
